// File: rtl/pam_pkg.sv
// Shared PAM transmit constants: Gray-coded DAC levels (12-bit offset binary), mid-scale and symbol helpers.
// Used by the mapper and by the pilot/sync generators downstream.
package pam_pkg;

    localparam logic [11:0] PAM_LVL_0  = 12'h200;
    localparam logic [11:0] PAM_LVL_1  = 12'h600;
    localparam logic [11:0] PAM_LVL_2  = 12'hA00;
    localparam logic [11:0] PAM_LVL_3  = 12'hE00;
    localparam logic [11:0] PAM2_LVL_0 = 12'h200;
    localparam logic [11:0] PAM2_LVL_1 = 12'hE00;
    localparam logic [11:0] PAM_MID    = 12'h800;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } map_state_e;

    function automatic int bits_per_sym(input int pam_order);
        return (pam_order == 2) ? 1 : 2;
    endfunction

    // Gray order: neighbouring levels differ in exactly one bit.
    function automatic logic [11:0] pam4_level(input logic [1:0] sym);
        case (sym)
            2'b00:   return PAM_LVL_0;
            2'b01:   return PAM_LVL_1;
            2'b11:   return PAM_LVL_2;
            default: return PAM_LVL_3;
        endcase
    endfunction

    function automatic logic [11:0] pam2_level(input logic bit_in);
        return bit_in ? PAM2_LVL_1 : PAM2_LVL_0;
    endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 byte source (x^7 + x^6 + 1, seed 7'h7F): o_byte holds the next 8 output bits MSB-first,
// and i_en advances the LFSR by those 8 steps.
module prbs7_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    output logic [7:0] o_byte
);

    logic [6:0] r_state;
    logic [6:0] w_next;

    always_comb begin
        logic [6:0] w_walk;
        w_walk = r_state;
        o_byte = '0;
        // NOTE: blocking assignments here chain the 8 LFSR steps within one evaluation.
        for (int i = 7; i >= 0; i--) begin
            o_byte[i] = w_walk[6];
            w_walk    = {w_walk[5:0], w_walk[6] ^ w_walk[5]};
        end
        w_next = w_walk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= 7'h7F;
        else if (i_en)
            r_state <= w_next;
    end

endmodule

// File: rtl/pam_map.sv
// PAM mapper: bytes split MSB-first into symbols, Gray-mapped to DAC levels, two samples per beat
// (earlier sample in the upper half). Define PAM_MAP_PRBS_EN to add the test_mode port and PRBS7 source.
module pam_map
    import pam_pkg::*;
#(
    parameter int AD_CVER_WIDTH = 12,
    parameter int PAM_ORDER     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   src_data,
    input  logic                         src_valid,
    output logic                         src_ready,
    output logic [2*AD_CVER_WIDTH-1:0]   PamMap2AddHead_data,
    output logic                         PamMap2AddHead_valid,
    input  logic                         PamMap2AddHead_ready
`ifdef PAM_MAP_PRBS_EN
    ,
    input  logic                         test_mode
`endif
);

    localparam int         BPS       = bits_per_sym(PAM_ORDER);
    localparam int         BEATS     = 8 / (2 * BPS);
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    if (PAM_ORDER != 2 && PAM_ORDER != 4) begin : g_bad_order
        $error("pam_map: PAM_ORDER must be 2 or 4");
    end

    map_state_e  r_state, w_state_nxt;
    logic [7:0]  r_byte_q;
    logic [1:0]  r_beat_cnt;
    logic        w_last_beat, w_load_out, w_src_take, w_prbs_take, w_test_mode;
    logic [7:0]  w_prbs_byte;
    logic [1:0]  w_pair;
    logic [3:0]  w_nib;
    logic [11:0] w_lvl_hi, w_lvl_lo;

`ifdef PAM_MAP_PRBS_EN
    assign w_test_mode = test_mode;

    prbs7_gen u_prbs (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_prbs_take),
        .o_byte (w_prbs_byte)
    );
`else
    assign w_test_mode = 1'b0;
    assign w_prbs_byte = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_src_take || w_prbs_take) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_last_beat && w_load_out)  w_state_nxt = w_src_take ? ST_FULL : ST_EMPTY;
        endcase
    end

    // src_ready looks through to the downstream ready so a new byte lands on the last beat's load.
    always_comb begin
        w_last_beat = (r_beat_cnt == LAST_BEAT);
        w_load_out  = (r_state == ST_FULL) && (!PamMap2AddHead_valid || PamMap2AddHead_ready);
        src_ready   = rst_n && !w_test_mode &&
                      ((r_state == ST_EMPTY) || (w_last_beat && w_load_out));
        w_src_take  = src_valid && src_ready;
        w_prbs_take = rst_n && (r_state == ST_EMPTY) && w_test_mode;
    end

    always_comb begin
        w_lvl_hi = PAM_MID;
        w_lvl_lo = PAM_MID;
        w_pair   = r_byte_q[7:6];
        case (r_beat_cnt)
            2'd0: w_pair = r_byte_q[7:6];
            2'd1: w_pair = r_byte_q[5:4];
            2'd2: w_pair = r_byte_q[3:2];
            2'd3: w_pair = r_byte_q[1:0];
        endcase
        w_nib = r_beat_cnt[0] ? r_byte_q[3:0] : r_byte_q[7:4];
        if (PAM_ORDER == 2) begin
            w_lvl_hi = pam2_level(w_pair[1]);
            w_lvl_lo = pam2_level(w_pair[0]);
        end else begin
            w_lvl_hi = pam4_level(w_nib[3:2]);
            w_lvl_lo = pam4_level(w_nib[1:0]);
        end
    end

    // NOTE: data registers are reset as well, so a byte cut short by reset leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_q   <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_src_take)
                r_byte_q <= src_data;
            else if (w_prbs_take)
                r_byte_q <= w_prbs_byte;
            if (w_load_out)
                r_beat_cnt <= w_last_beat ? 2'd0 : r_beat_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PamMap2AddHead_valid <= 1'b0;
            PamMap2AddHead_data  <= '0;
        end else if (w_load_out) begin
            PamMap2AddHead_valid <= 1'b1;
            PamMap2AddHead_data  <= {AD_CVER_WIDTH'(w_lvl_hi), AD_CVER_WIDTH'(w_lvl_lo)};
        end else if (PamMap2AddHead_ready) begin
            PamMap2AddHead_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pam_map.sv
// Self-checking bench for pam_map: one PAM4 and one PAM2 instance, directed scenarios plus
// randomized traffic scored against a symbol-level reference model.
`timescale 1ns/1ps
module tb_pam_map;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src_data [2];
    logic [1:0]  src_valid;
    logic [1:0]  out_ready;
    wire  [1:0]  src_ready;
    wire  [1:0]  out_valid;
    wire  [23:0] out_data4;
    wire  [23:0] out_data2;
    logic        test_mode = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pam_map #(.AD_CVER_WIDTH(12), .PAM_ORDER(4)) dut4 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .src_data             (src_data[0]),
        .src_valid            (src_valid[0]),
        .src_ready            (src_ready[0]),
        .PamMap2AddHead_data  (out_data4),
        .PamMap2AddHead_valid (out_valid[0]),
        .PamMap2AddHead_ready (out_ready[0])
`ifdef PAM_MAP_PRBS_EN
        , .test_mode          (test_mode)
`endif
    );

    pam_map #(.AD_CVER_WIDTH(12), .PAM_ORDER(2)) dut2 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .src_data             (src_data[1]),
        .src_valid            (src_valid[1]),
        .src_ready            (src_ready[1]),
        .PamMap2AddHead_data  (out_data2),
        .PamMap2AddHead_valid (out_valid[1]),
        .PamMap2AddHead_ready (out_ready[1])
`ifdef PAM_MAP_PRBS_EN
        , .test_mode          (test_mode)
`endif
    );

    function automatic logic [23:0] get_data(input int k);
        return (k == 0) ? out_data4 : out_data2;
    endfunction

    // Reference model: k=0 is PAM4 (Gray levels), k=1 is PAM2.
    function automatic logic [11:0] ref_level(input int k, input int sym);
        if (k == 1) return (sym != 0) ? 12'hE00 : 12'h200;
        case (sym)
            0:       return 12'h200;
            1:       return 12'h600;
            2:       return 12'hE00;
            default: return 12'hA00;
        endcase
    endfunction

    function automatic int ref_beats(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic logic [23:0] ref_beat(input int k, input logic [7:0] b, input int n);
        int bps = (k == 0) ? 2 : 1;
        int s0  = (int'(b) >> (8 - bps * (2 * n + 1))) & ((1 << bps) - 1);
        int s1  = (int'(b) >> (8 - bps * (2 * n + 2))) & ((1 << bps) - 1);
        return {ref_level(k, s0), ref_level(k, s1)};
    endfunction

    task automatic idle_inputs();
        src_valid   = 2'b00;
        out_ready   = 2'b11;
        src_data[0] = 8'h00;
        src_data[1] = 8'h00;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp += 3;
            if (out_valid[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid[%0d]: got %b, expected 0", k, out_valid[k]);
            end
            if (get_data(k) !== 24'h0) begin
                n_fail++; $display("FAIL reset_data[%0d]: got %h, expected 000000", k, get_data(k));
            end
            if (src_ready[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_src_ready[%0d]: got %b, expected 0", k, src_ready[k]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (src_ready[k] !== 1'b1) begin
                n_fail++; $display("FAIL post_reset_src_ready[%0d]: got %b, expected 1", k, src_ready[k]);
            end
        end
    endtask

    task automatic test_single(input int k, input logic [7:0] b);
        @(negedge clk);
        src_data[k] = b; src_valid[k] = 1'b1; out_ready[k] = 1'b1;
        #1;
        n_cmp++;
        if (src_ready[k] !== 1'b1) begin
            n_fail++; $display("FAIL single_src_ready[%0d]: got %b, expected 1", k, src_ready[k]);
        end
        @(negedge clk);
        src_valid[k] = 1'b0;
        n_cmp++;
        if (out_valid[k] !== 1'b0) begin
            n_fail++; $display("FAIL single_latency[%0d]: valid %b one edge after handshake, expected 0", k, out_valid[k]);
        end
        for (int n = 0; n < ref_beats(k); n++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid[k] !== 1'b1 || get_data(k) !== ref_beat(k, b, n)) begin
                n_fail++;
                $display("FAIL single_beat[%0d] byte %h beat %0d: got v=%b d=%h, expected v=1 d=%h",
                         k, b, n, out_valid[k], get_data(k), ref_beat(k, b, n));
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid[k] !== 1'b0) begin
            n_fail++; $display("FAIL single_tail[%0d]: valid %b after last beat, expected 0", k, out_valid[k]);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_beats [4];
        exp_beats[0] = 24'h200200; exp_beats[1] = 24'h200200;
        exp_beats[2] = 24'hA00A00; exp_beats[3] = 24'hA00A00;
        @(negedge clk);
        src_data[0] = 8'h00; src_valid[0] = 1'b1; out_ready[0] = 1'b1;
        #1;
        n_cmp++;
        if (src_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_first: got %b, expected 1", src_ready[0]);
        end
        @(negedge clk);
        src_data[0] = 8'hFF;
        #1;
        n_cmp++;
        if (src_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_mid: got %b, expected 0", src_ready[0]);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (src_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_last_beat: got %b, expected 1", src_ready[0]);
        end
        for (int n = 0; n < 4; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 1) src_valid[0] = 1'b0;
            n_cmp++;
            if (out_valid[0] !== 1'b1 || out_data4 !== exp_beats[n]) begin
                n_fail++;
                $display("FAIL b2b_beat %0d: got v=%b d=%h, expected v=1 d=%h", n, out_valid[0], out_data4, exp_beats[n]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_tail: valid %b, expected 0", out_valid[0]);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        src_data[0] = 8'h1B; src_valid[0] = 1'b1; out_ready[0] = 1'b1;
        @(negedge clk);
        src_valid[0] = 1'b0; out_ready[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (out_valid[0] !== 1'b1 || out_data4 !== 24'h200600 || src_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got v=%b d=%h rdy=%b, expected v=1 d=200600 rdy=0",
                         c, out_valid[0], out_data4, src_ready[0]);
            end
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid[0] !== 1'b1 || out_data4 !== 24'hE00A00) begin
            n_fail++; $display("FAIL bp_release: got v=%b d=%h, expected v=1 d=E00A00", out_valid[0], out_data4);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL bp_tail: valid %b, expected 0", out_valid[0]);
        end
    endtask

    task automatic test_reset_mid_byte();
        @(negedge clk);
        src_data[0] = 8'h1B; src_valid[0] = 1'b1; out_ready[0] = 1'b1;
        @(negedge clk);
        src_valid[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid[0] !== 1'b1 || out_data4 !== 24'h200600) begin
            n_fail++; $display("FAIL rst_mid_first_beat: got v=%b d=%h, expected v=1 d=200600", out_valid[0], out_data4);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || out_data4 !== 24'h0 || src_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got v=%b d=%h rdy=%b, expected v=0 d=000000 rdy=0",
                     out_valid[0], out_data4, src_ready[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_single(0, 8'h00);
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid[0] !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_stale_beat: valid %b d=%h, expected no beat", out_valid[0], out_data4);
            end
        end
    endtask

    task automatic test_random(input int k, input int n_cycles);
        logic [23:0] exp_q [$];
        logic [23:0] held = '0;
        logic [7:0]  pend = '0;
        logic        pend_v = 1'b0;
        logic        stalled = 1'b0;
        for (int cyc = 0; cyc < n_cycles + 24; cyc++) begin
            @(negedge clk);
            if (!pend_v && cyc < n_cycles && $urandom_range(0, 3) != 0) begin
                pend   = 8'($urandom);
                pend_v = 1'b1;
            end
            src_valid[k] = pend_v;
            src_data[k]  = pend;
            out_ready[k] = (cyc >= n_cycles) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (stalled) begin
                n_cmp++;
                if (out_valid[k] !== 1'b1 || get_data(k) !== held) begin
                    n_fail++;
                    $display("FAIL rand_hold[%0d] cyc %0d: got v=%b d=%h, expected v=1 d=%h",
                             k, cyc, out_valid[k], get_data(k), held);
                end
            end
            if (out_valid[k] === 1'b1 && out_ready[k]) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra_beat[%0d] cyc %0d: got d=%h, expected no beat", k, cyc, get_data(k));
                end else begin
                    if (get_data(k) !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL rand_beat[%0d] cyc %0d: got %h, expected %h", k, cyc, get_data(k), exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            stalled = (out_valid[k] === 1'b1) && !out_ready[k];
            held    = get_data(k);
            if (pend_v && src_ready[k] === 1'b1) begin
                for (int n = 0; n < ref_beats(k); n++) exp_q.push_back(ref_beat(k, pend, n));
                pend_v = 1'b0;
            end
        end
        src_valid[k] = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0 || pend_v) begin
            n_fail++;
            $display("FAIL rand_drain[%0d]: got %0d beats outstanding, pending byte %b, expected 0 and 0",
                     k, exp_q.size(), pend_v);
        end
    endtask

`ifdef PAM_MAP_PRBS_EN
    task automatic test_prbs();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        test_mode   = 1'b1;
        src_valid   = 2'b11;
        src_data[0] = 8'h55;
        src_data[1] = 8'h55;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (src_ready[k] !== 1'b0) begin
                    n_fail++; $display("FAIL prbs_src_ready[%0d] cyc %0d: got %b, expected 0", k, c, src_ready[k]);
                end
            end
            if (c >= 2) begin
                n_cmp++;
                if (c < 4 && (out_valid[0] !== 1'b1 || out_data4 !== ((c == 2) ? 24'hA00A00 : 24'hA00E00))) begin
                    n_fail++; $display("FAIL prbs_pam4 beat %0d: got v=%b d=%h", c - 2, out_valid[0], out_data4);
                end
                if (out_valid[1] !== 1'b1 || out_data2 !== ref_beat(1, 8'hFE, c - 2)) begin
                    n_fail++;
                    $display("FAIL prbs_pam2 beat %0d: got v=%b d=%h, expected v=1 d=%h",
                             c - 2, out_valid[1], out_data2, ref_beat(1, 8'hFE, c - 2));
                end
            end
            @(negedge clk);
        end
        test_mode = 1'b0;
        pulse_reset();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single(0, 8'h1B);
        test_single(1, 8'h1B);
        test_back_to_back();
        test_backpressure();
        test_reset_mid_byte();
        test_random(0, 400);
        test_random(1, 400);
`ifdef PAM_MAP_PRBS_EN
        test_prbs();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
